// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU command at a time, drives the captured
// opcode and operands to an external combinational ALU, samples its result
// one cycle later, and presents a checked response. Divide/modulo by zero and
// illegal opcodes are flagged with an error and a fixed data value.

module alu_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_op_i,
    input  logic [7:0]       cmd_a_i,
    input  logic [7:0]       cmd_b_i,
    output logic [2:0]       alu_ctrl_o,
    output logic [7:0]       alu_data0_o,
    output logic [7:0]       alu_data1_o,
    input  logic [7:0]       alu_result_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [7:0]       rsp_data_o,
    output logic             rsp_err_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] op_count_o
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_r;
    logic             cmd_ready_r;
    logic             busy_r;
    logic [2:0]       alu_ctrl_r;
    logic [7:0]       alu_a_r;
    logic [7:0]       alu_b_r;
    logic             rsp_valid_r;
    logic [7:0]       rsp_data_r;
    logic             rsp_err_r;
    logic [CNT_W-1:0] op_count_r;

    logic [7:0]       resp_data_s;
    logic             resp_err_s;

    // Response qualification: error cases override the ALU result entirely.
    always_comb begin
        resp_data_s = alu_result_i;
        resp_err_s  = 1'b0;
        case (alu_ctrl_r)
            OP_ADD, OP_SUB, OP_MUL: begin
                resp_data_s = alu_result_i;
                resp_err_s  = 1'b0;
            end
            OP_DIV, OP_MOD: begin
                if (alu_b_r == 8'h00) begin
                    resp_data_s = 8'hFF;
                    resp_err_s  = 1'b1;
                end else begin
                    resp_data_s = alu_result_i;
                    resp_err_s  = 1'b0;
                end
            end
            default: begin
                resp_data_s = 8'h00;
                resp_err_s  = 1'b1;
            end
        endcase
    end

    // Control FSM with all outputs registered; one command in flight at most.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            alu_ctrl_r  <= 3'b000;
            alu_a_r     <= 8'h00;
            alu_b_r     <= 8'h00;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 8'h00;
            rsp_err_r   <= 1'b0;
            op_count_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        alu_ctrl_r  <= cmd_op_i;
                        alu_a_r     <= cmd_a_i;
                        alu_b_r     <= cmd_b_i;
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= ST_EXEC;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    rsp_data_r  <= resp_data_s;
                    rsp_err_r   <= resp_err_s;
                    rsp_valid_r <= 1'b1;
                    state_r     <= ST_RESP;
                end
                ST_RESP: begin
                    // Ready is raised only after returning to IDLE, so a
                    // command presented during the handshake waits a cycle.
                    if (rsp_ready_i) begin
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        op_count_r  <= op_count_r + CNT_W'(1);
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_r;
    assign busy_o      = busy_r;
    assign alu_ctrl_o  = alu_ctrl_r;
    assign alu_data0_o = alu_a_r;
    assign alu_data1_o = alu_b_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_data_o  = rsp_data_r;
    assign rsp_err_o   = rsp_err_r;
    assign op_count_o  = op_count_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed and random commands, a
// behavioural response model, an external ALU model, and a negedge monitor.

module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [2:0] alu_ctrl;
    logic [7:0] alu_d0;
    logic [7:0] alu_d1;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;
    logic [7:0] op_count;

    int total = 0;
    int bad   = 0;
    int rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready

    // Scoreboard / model state
    logic [8:0] exp_q[$];
    bit         m_busy  = 1'b0;
    int         m_age   = 0;
    int         m_count = 0;
    logic [2:0] m_op    = 3'b000;
    logic [7:0] m_a     = 8'h00;
    logic [7:0] m_b     = 8'h00;

    always #5 clk = ~clk;

    alu_sequencer #(.CNT_W(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_a_i      (cmd_a),
        .cmd_b_i      (cmd_b),
        .alu_ctrl_o   (alu_ctrl),
        .alu_data0_o  (alu_d0),
        .alu_data1_o  (alu_d1),
        .alu_result_i (alu_result),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .rsp_err_o    (rsp_err),
        .busy_o       (busy),
        .op_count_o   (op_count)
    );

    // Downstream ALU model; error cases return junk the DUT must ignore.
    always_comb begin
        alu_result = 8'hC3;
        case (alu_ctrl)
            3'd0: alu_result = alu_d0 + alu_d1;
            3'd1: alu_result = alu_d0 - alu_d1;
            3'd2: alu_result = alu_d0 * alu_d1;
            3'd3: alu_result = (alu_d1 != 8'h00) ? alu_d0 / alu_d1 : 8'hA5;
            3'd4: alu_result = (alu_d1 != 8'h00) ? alu_d0 % alu_d1 : 8'h3C;
            default: alu_result = 8'hC3;
        endcase
    end

    // Expected {err, data} straight from the operation definitions.
    function automatic logic [8:0] ref_resp(input int op, input int a, input int b);
        case (op)
            0: return {1'b0, 8'((a + b) % 256)};
            1: return {1'b0, 8'((a - b + 256) % 256)};
            2: return {1'b0, 8'((a * b) % 256)};
            3: return (b == 0) ? 9'h1FF : {1'b0, 8'(a / b)};
            4: return (b == 0) ? 9'h1FF : {1'b0, 8'(a % b)};
            default: return 9'h100;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare outputs at negedge, then predict the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_data", rsp_data, 0);
            check("rst_rsp_err", rsp_err, 0);
            check("rst_busy", busy, 0);
            check("rst_cmd_ready", cmd_ready, 1);
            check("rst_alu_ctrl", alu_ctrl, 0);
            check("rst_alu_d0", alu_d0, 0);
            check("rst_alu_d1", alu_d1, 0);
            check("rst_op_count", op_count, 0);
            m_busy = 1'b0; m_age = 0; m_count = 0;
            m_op = 3'b000; m_a = 8'h00; m_b = 8'h00;
            exp_q.delete();
        end else begin
            check("cmd_ready", cmd_ready, {31'd0, !m_busy});
            check("busy", busy, {31'd0, m_busy});
            check("rsp_valid", rsp_valid, {31'd0, (m_busy && m_age >= 1)});
            check("op_count", op_count, m_count);
            check("alu_ctrl", alu_ctrl, m_op);
            check("alu_d0", alu_d0, m_a);
            check("alu_d1", alu_d1, m_b);
            if (m_busy && m_age >= 1) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL scoreboard_empty: got response with nothing expected");
                end else begin
                    check("rsp_data", rsp_data, exp_q[0][7:0]);
                    check("rsp_err", rsp_err, exp_q[0][8]);
                end
            end
            if (m_busy) begin
                if (m_age >= 1 && rsp_ready) begin
                    void'(exp_q.pop_front());
                    m_busy  = 1'b0;
                    m_count = (m_count + 1) % 256;
                end else begin
                    m_age++;
                end
            end else if (cmd_valid) begin
                m_busy = 1'b1;
                m_age  = 0;
                m_op   = cmd_op;
                m_a    = cmd_a;
                m_b    = cmd_b;
                exp_q.push_back(ref_resp(cmd_op, cmd_a, cmd_b));
            end
        end
    end

    // Response-ready driver
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: rsp_ready = ($urandom_range(0, 3) != 0);
                1: rsp_ready = 1'b1;
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    task automatic wait_accept(output int n);
        bit done = 1'b0;
        n = 0;
        while (!done) begin
            @(negedge clk);
            if (cmd_ready) begin
                done = 1'b1;
            end else begin
                n++;
                if (n > 200) begin
                    total++; bad++;
                    $display("FAIL accept_timeout: waited %0d cycles", n);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        @(posedge clk);
        #2;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        wait_accept(n);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n <= 200) begin
            @(negedge clk);
            n++;
        end
        if (n > 200) begin
            total++; bad++;
            $display("FAIL idle_timeout: busy=%0b after %0d cycles", busy, n);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] rb;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = 3'b000; cmd_a = 8'h00; cmd_b = 8'h00;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed: add, wrapping mul, div by zero, illegal op, sub wrap, mod
        rdy_mode = 1;
        send(3'b000, 8'd25, 8'd17);
        wait_idle();
        check("add_count", op_count, 1);
        send(3'b010, 8'd20, 8'd13);
        send(3'b011, 8'd200, 8'd0);
        send(3'b110, 8'd3, 8'd4);
        send(3'b001, 8'd5, 8'd9);
        send(3'b100, 8'd200, 8'd7);
        send(3'b100, 8'd9, 8'd0);
        send(3'b111, 8'd1, 8'd1);
        wait_idle();
        check("directed_count", op_count, 8);

        // Backpressure: response held, a new command is presented and ignored
        rdy_mode = 2;
        send(3'b000, 8'd100, 8'd50);
        @(posedge clk);
        #2;
        cmd_valid = 1'b1; cmd_op = 3'b001; cmd_a = 8'd9; cmd_b = 8'd4;
        repeat (4) @(negedge clk);
        check("bp_ready_low", cmd_ready, 0);
        check("bp_valid_high", rsp_valid, 1);
        check("bp_data", rsp_data, 150);
        rdy_mode = 1;
        wait_accept(n);
        wait_idle();
        check("bp_count", op_count, 10);

        // Asynchronous reset while in EXEC
        send(3'b010, 8'd7, 8'd9);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_valid", rsp_valid, 0);
        check("async_rst_count", op_count, 0);
        check("async_rst_ready", cmd_ready, 1);
        check("async_rst_ctrl", alu_ctrl, 0);
        check("async_rst_d0", alu_d0, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = 8'd1; cmd_b = 8'd2;
        wait_accept(n);
        check("accept_after_release", n, 0);

        // Counter wrap: 255 more operations make 256 since reset
        rdy_mode = 0;
        for (int i = 0; i < 255; i++) begin
            rb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            send(3'($urandom_range(0, 7)), 8'($urandom), rb);
        end
        wait_idle();
        check("count_wrap", op_count, 0);

        // Random traffic with gaps
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            rb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            send(3'($urandom_range(0, 7)), 8'($urandom), rb);
        end
        rdy_mode = 1;
        wait_idle();
        check("final_count", op_count, 120);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
